// File: rtl/culsans_rd_addr_router.sv
// Read-path address router: decodes AR addresses against a runtime rule table, forwards the
// request to one downstream port, muxes R back in order and answers unmapped reads with DECERR.
module culsans_rd_addr_router #(
  parameter int unsigned NumMst    = 2,
  parameter int unsigned NumRules  = 10,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned MaxTxns   = 8,
  localparam int unsigned TW = $clog2(NumMst + 1),
  localparam int unsigned CW = $clog2(MaxTxns + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumRules*AddrWidth-1:0] rule_base_i,
  input  logic [NumRules*AddrWidth-1:0] rule_len_i,
  input  logic [NumRules*TW-1:0]        rule_port_i,
  input  logic                          slv_ar_valid_i,
  output logic                          slv_ar_ready_o,
  input  logic [AddrWidth-1:0]          slv_ar_addr_i,
  input  logic [IdWidth-1:0]            slv_ar_id_i,
  input  logic [7:0]                    slv_ar_len_i,
  output logic                          slv_r_valid_o,
  input  logic                          slv_r_ready_i,
  output logic [IdWidth-1:0]            slv_r_id_o,
  output logic [DataWidth-1:0]          slv_r_data_o,
  output logic [3:0]                    slv_r_resp_o,
  output logic                          slv_r_last_o,
  output logic [NumMst-1:0]             mst_ar_valid_o,
  input  logic [NumMst-1:0]             mst_ar_ready_i,
  output logic [AddrWidth-1:0]          mst_ar_addr_o,
  output logic [IdWidth-1:0]            mst_ar_id_o,
  output logic [7:0]                    mst_ar_len_o,
  input  logic [NumMst-1:0]             mst_r_valid_i,
  output logic [NumMst-1:0]             mst_r_ready_o,
  input  logic [NumMst*IdWidth-1:0]     mst_r_id_i,
  input  logic [NumMst*DataWidth-1:0]   mst_r_data_i,
  input  logic [NumMst*4-1:0]           mst_r_resp_i,
  input  logic [NumMst-1:0]             mst_r_last_i
);

  typedef enum logic {ERR_IDLE, ERR_BUSY} err_state_e;

  localparam logic [TW-1:0] ErrTgt = TW'(NumMst);

  err_state_e         err_state_q, err_state_d;
  logic [TW-1:0]      tgt, cur_tgt;
  logic [CW-1:0]      cnt;
  logic [IdWidth-1:0] err_id;
  logic [7:0]         err_beats;
  logic [AddrWidth:0] rule_lo, rule_hi;
  logic               tgt_is_err, cur_is_err, ar_allowed, ar_hs, r_last_hs, err_r_hs;

  // Walk the table from the top so the lowest-numbered hitting rule is the one left standing.
  always_comb begin
    tgt     = ErrTgt;
    rule_lo = '0;
    rule_hi = '0;
    for (int k = NumRules - 1; k >= 0; k--) begin
      rule_lo = {1'b0, rule_base_i[k*AddrWidth +: AddrWidth]};
      rule_hi = rule_lo + {1'b0, rule_len_i[k*AddrWidth +: AddrWidth]};
      if (({1'b0, slv_ar_addr_i} >= rule_lo) && ({1'b0, slv_ar_addr_i} < rule_hi)) begin
        tgt = rule_port_i[k*TW +: TW];
      end
    end
  end

  assign tgt_is_err = (tgt >= ErrTgt);
  assign cur_is_err = (cur_tgt >= ErrTgt);

  always_comb begin
    ar_allowed = 1'b0;
    if (rst_ni) begin
      if (tgt_is_err) begin
        ar_allowed = (cnt == '0) && (err_state_q == ERR_IDLE);
      end else begin
        ar_allowed = (cnt == '0) || ((tgt == cur_tgt) && (cnt < CW'(MaxTxns)));
      end
    end
  end

  always_comb begin
    mst_ar_valid_o = '0;
    slv_ar_ready_o = 1'b0;
    if (ar_allowed) begin
      if (tgt_is_err) begin
        slv_ar_ready_o = 1'b1;
      end else begin
        for (int p = 0; p < NumMst; p++) begin
          if (tgt == TW'(p)) begin
            mst_ar_valid_o[p] = slv_ar_valid_i;
            slv_ar_ready_o    = mst_ar_ready_i[p];
          end
        end
      end
    end
  end

  assign mst_ar_addr_o = slv_ar_addr_i;
  assign mst_ar_id_o   = slv_ar_id_i;
  assign mst_ar_len_o  = slv_ar_len_i;
  assign ar_hs         = slv_ar_valid_i & slv_ar_ready_o;

  // R is only routed while reads are outstanding, so stray downstream beats never leak upstream.
  always_comb begin
    slv_r_valid_o = 1'b0;
    slv_r_id_o    = '0;
    slv_r_data_o  = '0;
    slv_r_resp_o  = '0;
    slv_r_last_o  = 1'b0;
    mst_r_ready_o = '0;
    if (rst_ni && (cnt != '0)) begin
      if (cur_is_err) begin
        if (err_state_q == ERR_BUSY) begin
          slv_r_valid_o = 1'b1;
          slv_r_id_o    = err_id;
          slv_r_resp_o  = 4'b0011;
          slv_r_last_o  = (err_beats == 8'd0);
        end
      end else begin
        for (int p = 0; p < NumMst; p++) begin
          if (cur_tgt == TW'(p)) begin
            slv_r_valid_o    = mst_r_valid_i[p];
            slv_r_id_o       = mst_r_id_i[p*IdWidth +: IdWidth];
            slv_r_data_o     = mst_r_data_i[p*DataWidth +: DataWidth];
            slv_r_resp_o     = mst_r_resp_i[p*4 +: 4];
            slv_r_last_o     = mst_r_last_i[p];
            mst_r_ready_o[p] = slv_r_ready_i;
          end
        end
      end
    end
  end

  assign r_last_hs = slv_r_valid_o & slv_r_ready_i & slv_r_last_o;
  assign err_r_hs  = cur_is_err & slv_r_valid_o & slv_r_ready_i;

  always_comb begin
    err_state_d = err_state_q;
    case (err_state_q)
      ERR_IDLE: if (ar_hs && tgt_is_err) err_state_d = ERR_BUSY;
      ERR_BUSY: if (err_r_hs && (err_beats == 8'd0)) err_state_d = ERR_IDLE;
      default:  err_state_d = ERR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_state_q <= ERR_IDLE;
      err_id      <= '0;
      err_beats   <= '0;
      cnt         <= '0;
      cur_tgt     <= '0;
    end else begin
      err_state_q <= err_state_d;
      if (ar_hs) cur_tgt <= tgt;
      if (ar_hs && !r_last_hs) begin
        cnt <= cnt + CW'(1);
      end else if (!ar_hs && r_last_hs) begin
        cnt <= cnt - CW'(1);
      end
      if (ar_hs && tgt_is_err) begin
        err_id    <= slv_ar_id_i;
        err_beats <= slv_ar_len_i;
      end else if (err_r_hs && (err_beats != 8'd0)) begin
        err_beats <= err_beats - 8'd1;
      end
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) r_last_hs |-> (cnt != '0));
  assert property (@(posedge clk_i) disable iff (!rst_ni) cnt <= CW'(MaxTxns));
  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(mst_ar_valid_o));
`endif

endmodule

// File: tb/tb_culsans_rd_addr_router.sv
// Directed bench for culsans_rd_addr_router: decode, R muxing, ordering stalls, MaxTxns limit,
// DECERR bursts with backpressure and reset in the middle of a burst.
module tb_culsans_rd_addr_router;

  localparam int NumMst    = 2;
  localparam int NumRules  = 5;
  localparam int AddrWidth = 32;
  localparam int DataWidth = 32;
  localparam int IdWidth   = 4;
  localparam int MaxTxns   = 4;
  localparam int TW        = $clog2(NumMst + 1);

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NumRules*AddrWidth-1:0] rule_base, rule_len;
  logic [NumRules*TW-1:0]        rule_port;
  logic                          slv_ar_valid, slv_ar_ready;
  logic [AddrWidth-1:0]          slv_ar_addr;
  logic [IdWidth-1:0]            slv_ar_id;
  logic [7:0]                    slv_ar_len;
  logic                          slv_r_valid, slv_r_ready, slv_r_last;
  logic [IdWidth-1:0]            slv_r_id;
  logic [DataWidth-1:0]          slv_r_data;
  logic [3:0]                    slv_r_resp;
  logic [NumMst-1:0]             mst_ar_valid, mst_ar_ready;
  logic [AddrWidth-1:0]          mst_ar_addr;
  logic [IdWidth-1:0]            mst_ar_id;
  logic [7:0]                    mst_ar_len;
  logic [NumMst-1:0]             mst_r_valid, mst_r_ready, mst_r_last;
  logic [NumMst*IdWidth-1:0]     mst_r_id;
  logic [NumMst*DataWidth-1:0]   mst_r_data;
  logic [NumMst*4-1:0]           mst_r_resp;

  int n_checks = 0;
  int n_fail   = 0;

  culsans_rd_addr_router #(
    .NumMst(NumMst), .NumRules(NumRules), .AddrWidth(AddrWidth),
    .DataWidth(DataWidth), .IdWidth(IdWidth), .MaxTxns(MaxTxns)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rule_base_i(rule_base), .rule_len_i(rule_len), .rule_port_i(rule_port),
    .slv_ar_valid_i(slv_ar_valid), .slv_ar_ready_o(slv_ar_ready), .slv_ar_addr_i(slv_ar_addr),
    .slv_ar_id_i(slv_ar_id), .slv_ar_len_i(slv_ar_len),
    .slv_r_valid_o(slv_r_valid), .slv_r_ready_i(slv_r_ready), .slv_r_id_o(slv_r_id),
    .slv_r_data_o(slv_r_data), .slv_r_resp_o(slv_r_resp), .slv_r_last_o(slv_r_last),
    .mst_ar_valid_o(mst_ar_valid), .mst_ar_ready_i(mst_ar_ready), .mst_ar_addr_o(mst_ar_addr),
    .mst_ar_id_o(mst_ar_id), .mst_ar_len_o(mst_ar_len),
    .mst_r_valid_i(mst_r_valid), .mst_r_ready_o(mst_r_ready), .mst_r_id_i(mst_r_id),
    .mst_r_data_i(mst_r_data), .mst_r_resp_i(mst_r_resp), .mst_r_last_i(mst_r_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_rule(input int k, input logic [31:0] base, input logic [31:0] len,
                          input logic [TW-1:0] port);
    rule_base[k*AddrWidth +: AddrWidth] = base;
    rule_len[k*AddrWidth +: AddrWidth]  = len;
    rule_port[k*TW +: TW]               = port;
  endtask

  task automatic drive_ar(input logic v, input logic [31:0] addr, input logic [3:0] id,
                          input logic [7:0] len);
    slv_ar_valid = v;
    slv_ar_addr  = addr;
    slv_ar_id    = id;
    slv_ar_len   = len;
  endtask

  task automatic drive_r(input int p, input logic v, input logic [3:0] id,
                         input logic [31:0] data, input logic [3:0] resp, input logic last);
    mst_r_valid[p]                        = v;
    mst_r_id[p*IdWidth +: IdWidth]        = id;
    mst_r_data[p*DataWidth +: DataWidth]  = data;
    mst_r_resp[p*4 +: 4]                  = resp;
    mst_r_last[p]                         = last;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rule_base = '0; rule_len = '0; rule_port = '0;
    set_rule(0, 32'h8000_0000, 32'h4000_0000, 2'd0);
    set_rule(1, 32'hD000_0000, 32'h0000_1000, 2'd1);
    set_rule(2, 32'hFFFF_F000, 32'h0000_2000, 2'd1);
    set_rule(3, 32'h1000_0000, 32'h1000_0000, 2'd0);
    set_rule(4, 32'h5000_0000, 32'h0000_0000, 2'd0);
    mst_r_valid = '0; mst_r_id = '0; mst_r_data = '0; mst_r_resp = '0; mst_r_last = '0;
    @(negedge clk);
    drive_ar(1'b1, 32'h8000_1000, 4'h1, 8'd0);
    mst_ar_ready = 2'b01;
    slv_r_ready  = 1'b1;
    drive_r(0, 1'b1, 4'h1, 32'h1234, 4'b0000, 1'b1);
    #1;
    n_checks++;
    if ({slv_ar_ready, mst_ar_valid, slv_r_valid, mst_r_ready} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b expected %b",
               {slv_ar_ready, mst_ar_valid, slv_r_valid, mst_r_ready}, 5'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_ar(1'b0, 32'h0, 4'h0, 8'd0);
    #1;
    n_checks++;
    if ({slv_r_valid, mst_r_ready} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL post_reset_r_idle: got %b expected %b", {slv_r_valid, mst_r_ready}, 3'b000);
    end
    drive_r(0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic test_route_port0();
    @(negedge clk);
    mst_ar_ready = 2'b01;
    drive_ar(1'b1, 32'h8000_1000, 4'h3, 8'd3);
    #1;
    n_checks++;
    if ({mst_ar_valid, slv_ar_ready, mst_ar_addr, mst_ar_id, mst_ar_len} !==
        {2'b01, 1'b1, 32'h8000_1000, 4'h3, 8'd3}) begin
      n_fail++;
      $display("[TB] FAIL route_ar: got %h expected %h",
               {mst_ar_valid, slv_ar_ready, mst_ar_addr, mst_ar_id, mst_ar_len},
               {2'b01, 1'b1, 32'h8000_1000, 4'h3, 8'd3});
    end
    @(negedge clk);
    drive_ar(1'b0, 32'h0, 4'h0, 8'd0);
    slv_r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_r(0, 1'b1, 4'h3, 32'(160 + i), 4'b0100, (i == 3));
      #1;
      n_checks++;
      if ({slv_r_valid, slv_r_last, slv_r_id, slv_r_data, slv_r_resp, mst_r_ready} !==
          {1'b1, (i == 3), 4'h3, 32'(160 + i), 4'b0100, 2'b01}) begin
        n_fail++;
        $display("[TB] FAIL route_r_beat%0d: got %h expected %h", i,
                 {slv_r_valid, slv_r_last, slv_r_id, slv_r_data, slv_r_resp, mst_r_ready},
                 {1'b1, (i == 3), 4'h3, 32'(160 + i), 4'b0100, 2'b01});
      end
      @(negedge clk);
    end
    drive_r(0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
    mst_ar_ready = 2'b10;
    drive_ar(1'b1, 32'hD000_0010, 4'h4, 8'd0);
    #1;
    n_checks++;
    if ({mst_ar_valid, slv_ar_ready} !== 3'b101) begin
      n_fail++;
      $display("[TB] FAIL route_cnt_zero: got %b expected %b", {mst_ar_valid, slv_ar_ready}, 3'b101);
    end
    #1;
    drive_ar(1'b0, 32'h0, 4'h0, 8'd0);
  endtask

  task automatic test_decode();
    logic [31:0] dec_addr [9];
    logic [2:0]  dec_exp  [9];
    dec_addr = '{32'h8000_0000, 32'hBFFF_FFFF, 32'hC000_0000, 32'hD000_0FFF, 32'hD000_1000,
                 32'hFFFF_FFFF, 32'h0000_0000, 32'h1000_0000, 32'h5000_0000};
    dec_exp  = '{3'b010, 3'b010, 3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b010, 3'b001};
    mst_ar_ready = 2'b00;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_ar(1'b1, dec_addr[i], 4'h0, 8'd0);
      #1;
      n_checks++;
      if ({mst_ar_valid, slv_ar_ready} !== dec_exp[i]) begin
        n_fail++;
        $display("[TB] FAIL decode_%h: got %b expected %b", dec_addr[i],
                 {mst_ar_valid, slv_ar_ready}, dec_exp[i]);
      end
      #1;
      drive_ar(1'b0, 32'h0, 4'h0, 8'd0);
    end
  endtask

  task automatic test_err_burst();
    @(negedge clk);
    mst_ar_ready = 2'b00;
    slv_r_ready  = 1'b1;
    drive_ar(1'b1, 32'h5000_0000, 4'h5, 8'd1);
    #1;
    n_checks++;
    if ({mst_ar_valid, slv_ar_ready} !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL err_ar: got %b expected %b", {mst_ar_valid, slv_ar_ready}, 3'b001);
    end
    @(negedge clk);
    mst_ar_ready = 2'b01;
    drive_ar(1'b1, 32'h8000_0000, 4'h0, 8'd0);
    #1;
    n_checks++;
    if ({slv_r_valid, slv_r_id, slv_r_data, slv_r_resp, slv_r_last, slv_ar_ready, mst_ar_valid} !==
        {1'b1, 4'h5, 32'h0, 4'b0011, 1'b0, 1'b0, 2'b00}) begin
      n_fail++;
      $display("[TB] FAIL err_beat0: got %h expected %h",
               {slv_r_valid, slv_r_id, slv_r_data, slv_r_resp, slv_r_last, slv_ar_ready, mst_ar_valid},
               {1'b1, 4'h5, 32'h0, 4'b0011, 1'b0, 1'b0, 2'b00});
    end
    #1;
    drive_ar(1'b0, 32'h0, 4'h0, 8'd0);
    @(negedge clk);
    #1;
    n_checks++;
    if ({slv_r_valid, slv_r_id, slv_r_data, slv_r_resp, slv_r_last} !== {1'b1, 4'h5, 32'h0, 4'b0011, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL err_beat1: got %h expected %h",
               {slv_r_valid, slv_r_id, slv_r_data, slv_r_resp, slv_r_last}, {1'b1, 4'h5, 32'h0, 4'b0011, 1'b1});
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (slv_r_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL err_done: got %b expected %b", slv_r_valid, 1'b0);
    end
  endtask

  task automatic test_ordering();
    mst_ar_ready = 2'b11;
    slv_r_ready  = 1'b1;
    @(negedge clk);
    drive_ar(1'b1, 32'h8000_0000, 4'h1, 8'd0);
    @(negedge clk);
    drive_ar(1'b1, 32'h8000_0040, 4'h2, 8'd0);
    @(negedge clk);
    drive_ar(1'b1, 32'hD000_0000, 4'h3, 8'd0);
    #1;
    n_checks++;
    if ({mst_ar_valid, slv_ar_ready} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL order_stall: got %b expected %b", {mst_ar_valid, slv_ar_ready}, 3'b000);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_r(0, 1'b1, 4'(i + 1), 32'h0, 4'h0, 1'b1);
      #1;
      n_checks++;
      if ({mst_ar_valid, slv_ar_ready, slv_r_valid, slv_r_id} !== {3'b000, 1'b1, 4'(i + 1)}) begin
        n_fail++;
        $display("[TB] FAIL order_drain%0d: got %b expected %b", i,
                 {mst_ar_valid, slv_ar_ready, slv_r_valid, slv_r_id}, {3'b000, 1'b1, 4'(i + 1)});
      end
    end
    @(negedge clk);
    drive_r(0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
    #1;
    n_checks++;
    if ({mst_ar_valid, slv_ar_ready} !== 3'b101) begin
      n_fail++;
      $display("[TB] FAIL order_release: got %b expected %b", {mst_ar_valid, slv_ar_ready}, 3'b101);
    end
    @(negedge clk);
    drive_ar(1'b0, 32'h0, 4'h0, 8'd0);
    drive_r(1, 1'b1, 4'h3, 32'hCAFE_0001, 4'b0001, 1'b1);
    #1;
    n_checks++;
    if ({slv_r_valid, slv_r_id, slv_r_data, mst_r_ready} !== {1'b1, 4'h3, 32'hCAFE_0001, 2'b10}) begin
      n_fail++;
      $display("[TB] FAIL order_port1_r: got %h expected %h",
               {slv_r_valid, slv_r_id, slv_r_data, mst_r_ready}, {1'b1, 4'h3, 32'hCAFE_0001, 2'b10});
    end
    @(negedge clk);
    drive_r(1, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic test_max_txns();
    mst_ar_ready = 2'b01;
    slv_r_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_ar(1'b1, 32'h8000_0000 + 32'(i * 64), 4'(i), 8'd0);
      #1;
      n_checks++;
      if (slv_ar_ready !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL max_fill%0d: got %b expected %b", i, slv_ar_ready, 1'b1);
      end
    end
    @(negedge clk);
    drive_ar(1'b1, 32'h8000_0100, 4'hA, 8'd0);
    #1;
    n_checks++;
    if ({mst_ar_valid, slv_ar_ready} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL max_full: got %b expected %b", {mst_ar_valid, slv_ar_ready}, 3'b000);
    end
    @(negedge clk);
    drive_r(0, 1'b1, 4'h0, 32'h0, 4'h0, 1'b1);
    #1;
    n_checks++;
    if ({slv_ar_ready, slv_r_valid} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL max_r_while_full: got %b expected %b", {slv_ar_ready, slv_r_valid}, 2'b01);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({slv_ar_ready, slv_r_valid} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL max_ar_and_r: got %b expected %b", {slv_ar_ready, slv_r_valid}, 2'b11);
    end
    @(negedge clk);
    drive_r(0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
    drive_ar(1'b1, 32'h8000_0140, 4'hB, 8'd0);
    #1;
    n_checks++;
    if (slv_ar_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL max_refill: got %b expected %b", slv_ar_ready, 1'b1);
    end
    @(negedge clk);
    drive_ar(1'b1, 32'h8000_0180, 4'hC, 8'd0);
    #1;
    n_checks++;
    if (slv_ar_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL max_full_again: got %b expected %b", slv_ar_ready, 1'b0);
    end
    #1;
    drive_ar(1'b0, 32'h0, 4'h0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_r(0, 1'b1, 4'h0, 32'h0, 4'h0, 1'b1);
    end
    @(negedge clk);
    drive_r(0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
    mst_ar_ready = 2'b10;
    drive_ar(1'b1, 32'hD000_0000, 4'h0, 8'd0);
    #1;
    n_checks++;
    if ({mst_ar_valid, slv_ar_ready} !== 3'b101) begin
      n_fail++;
      $display("[TB] FAIL max_drained: got %b expected %b", {mst_ar_valid, slv_ar_ready}, 3'b101);
    end
    #1;
    drive_ar(1'b0, 32'h0, 4'h0, 8'd0);
  endtask

  task automatic test_overlap_backpressure();
    @(negedge clk);
    set_rule(0, 32'h0800_0000, 32'h1000_0000, 2'd1);
    mst_ar_ready = 2'b00;
    drive_ar(1'b1, 32'h1000_0000, 4'h0, 8'd0);
    #1;
    n_checks++;
    if ({mst_ar_valid, slv_ar_ready} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL overlap_lowest_rule: got %b expected %b", {mst_ar_valid, slv_ar_ready}, 3'b100);
    end
    #1;
    drive_ar(1'b0, 32'h0, 4'h0, 8'd0);
    set_rule(0, 32'h8000_0000, 32'h4000_0000, 2'd0);
    @(negedge clk);
    slv_r_ready = 1'b0;
    drive_ar(1'b1, 32'hC000_0000, 4'h9, 8'd2);
    @(negedge clk);
    drive_ar(1'b0, 32'h0, 4'h0, 8'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({slv_r_valid, slv_r_id, slv_r_data, slv_r_resp, slv_r_last} !== {1'b1, 4'h9, 32'h0, 4'b0011, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL err_hold%0d: got %h expected %h", i,
                 {slv_r_valid, slv_r_id, slv_r_data, slv_r_resp, slv_r_last}, {1'b1, 4'h9, 32'h0, 4'b0011, 1'b0});
      end
      @(negedge clk);
    end
    slv_r_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({slv_r_valid, slv_r_id, slv_r_resp, slv_r_last} !== {1'b1, 4'h9, 4'b0011, (i == 2)}) begin
        n_fail++;
        $display("[TB] FAIL err_bp_beat%0d: got %h expected %h", i,
                 {slv_r_valid, slv_r_id, slv_r_resp, slv_r_last}, {1'b1, 4'h9, 4'b0011, (i == 2)});
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (slv_r_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL err_bp_done: got %b expected %b", slv_r_valid, 1'b0);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    slv_r_ready = 1'b1;
    drive_ar(1'b1, 32'hC000_0000, 4'h6, 8'd3);
    @(negedge clk);
    drive_ar(1'b0, 32'h0, 4'h0, 8'd0);
    #1;
    n_checks++;
    if ({slv_r_valid, slv_r_id, slv_r_last} !== {1'b1, 4'h6, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL rst_burst_beat0: got %h expected %h", {slv_r_valid, slv_r_id, slv_r_last}, {1'b1, 4'h6, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({slv_r_valid, slv_ar_ready} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL rst_during: got %b expected %b", {slv_r_valid, slv_ar_ready}, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (slv_r_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL rst_abandon%0d: got %b expected %b", i, slv_r_valid, 1'b0);
      end
      @(negedge clk);
    end
    mst_ar_ready = 2'b01;
    drive_ar(1'b1, 32'h8000_0000, 4'h7, 8'd0);
    #1;
    n_checks++;
    if ({mst_ar_valid, slv_ar_ready} !== 3'b011) begin
      n_fail++;
      $display("[TB] FAIL rst_fresh_ar: got %b expected %b", {mst_ar_valid, slv_ar_ready}, 3'b011);
    end
    @(negedge clk);
    drive_ar(1'b0, 32'h0, 4'h0, 8'd0);
    drive_r(0, 1'b1, 4'h7, 32'hBEEF, 4'h0, 1'b1);
    #1;
    n_checks++;
    if ({slv_r_valid, slv_r_id, slv_r_data, slv_r_last} !== {1'b1, 4'h7, 32'hBEEF, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL rst_fresh_r: got %h expected %h", {slv_r_valid, slv_r_id, slv_r_data, slv_r_last}, {1'b1, 4'h7, 32'hBEEF, 1'b1});
    end
    @(negedge clk);
    drive_r(0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
  endtask

  initial begin
    drive_ar(1'b0, 32'h0, 4'h0, 8'd0);
    mst_ar_ready = '0;
    slv_r_ready  = 1'b0;
    test_reset();
    test_route_port0();
    test_decode();
    test_err_burst();
    test_ordering();
    test_max_txns();
    test_overlap_backpressure();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
